// File: rtl/spi_cfg_sequencer.sv
// spi_cfg_sequencer: pulses the device hard reset, waits out recovery, then
// walks a synchronous-ROM table of SPI register operations (write, read,
// delay, poll, end) and hands each SPI access to an external engine.
module spi_cfg_sequencer #(
    parameter int  ADDR_W     = 7,
    parameter int  DATA_W     = 8,
    parameter int  DEPTH      = 64,
    parameter int  RST_HI_CYC = 10000,
    parameter int  RST_LO_CYC = 20000,
    parameter int  POLL_MAX   = 255,
    localparam int PTR_W      = $clog2(DEPTH),
    localparam int ENTRY_W    = 3 + ADDR_W + 2 * DATA_W,
    localparam int CMD_W      = 1 + ADDR_W + DATA_W
) (
    input  logic               clk_in,
    input  logic               rst_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [PTR_W-1:0]   err_ptr,
    output logic               o_reset,
    output logic [PTR_W-1:0]   tbl_addr,
    input  logic [ENTRY_W-1:0] tbl_data,
    output logic               cmd_valid,
    input  logic               cmd_ready,
    output logic [CMD_W-1:0]   cmd_word,
    input  logic               rsp_valid,
    input  logic [DATA_W-1:0]  rsp_data,
    output logic [DATA_W-1:0]  last_rd
);

    localparam logic [2:0] OP_WRITE = 3'd0;
    localparam logic [2:0] OP_READ  = 3'd1;
    localparam logic [2:0] OP_DELAY = 3'd2;
    localparam logic [2:0] OP_POLL  = 3'd3;
    localparam logic [2:0] OP_END   = 3'd4;

    // One counter serves both reset phases, so size it for the longer one.
    localparam int RST_MAX = (RST_HI_CYC > RST_LO_CYC) ? RST_HI_CYC : RST_LO_CYC;
    localparam int RCNT_W  = $clog2(RST_MAX + 1);
    localparam int PCNT_W  = $clog2(POLL_MAX + 1);

    localparam logic [RCNT_W-1:0] HI_LAST   = RCNT_W'(RST_HI_CYC - 1);
    localparam logic [RCNT_W-1:0] LO_LAST   = RCNT_W'(RST_LO_CYC - 1);
    localparam logic [PCNT_W-1:0] POLL_LAST = PCNT_W'(POLL_MAX - 1);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(DEPTH - 1);

    typedef enum logic [3:0] {
        ST_IDLE, ST_RST_H, ST_RST_L, ST_FETCH, ST_DECODE,
        ST_ISSUE, ST_WAIT_RSP, ST_DELAY, ST_DONE, ST_ERR
    } state_t;

    state_t              state, state_nxt;
    logic [PTR_W-1:0]    ptr;
    logic [ENTRY_W-1:0]  entry;
    logic [RCNT_W-1:0]   rst_cnt;
    logic [PCNT_W-1:0]   poll_cnt;
    logic [DATA_W-1:0]   dly_cnt;

    // Fields of the entry being executed and of the word arriving from the ROM.
    logic [2:0]          ent_op, dec_op;
    logic [ADDR_W-1:0]   ent_addr;
    logic [DATA_W-1:0]   ent_data, ent_mask;
    logic                rd_op, poll_miss, is_last, step;
    state_t              adv_state;

    assign ent_op   = entry[ENTRY_W-1 -: 3];
    assign ent_addr = entry[2*DATA_W +: ADDR_W];
    assign ent_data = entry[DATA_W +: DATA_W];
    assign ent_mask = entry[0 +: DATA_W];
    assign dec_op   = tbl_data[ENTRY_W-1 -: 3];

    assign rd_op     = (ent_op == OP_READ) || (ent_op == OP_POLL);
    assign poll_miss = (ent_op == OP_POLL) && (((rsp_data ^ ent_data) & ent_mask) != '0);
    assign is_last   = (ptr == PTR_LAST);
    // The last table slot never wraps: finishing it without an END is an error.
    assign adv_state = is_last ? ST_ERR : ST_FETCH;
    // The current entry has finished and the walk moves to the next one.
    assign step = ((state == ST_WAIT_RSP) && rsp_valid && !poll_miss) ||
                  ((state == ST_DELAY) && (dly_cnt == ent_data));
    assign tbl_addr = ptr;

    // State register.
    always_ff @(posedge clk_in) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of block evaluation order.
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        // NOTE: the default at the top covers every path, so no latch is inferred.
        state_nxt = state;
        case (state)
            ST_IDLE:     if (start) state_nxt = ST_RST_H;
            ST_RST_H:    if (rst_cnt == HI_LAST) state_nxt = ST_RST_L;
            ST_RST_L:    if (rst_cnt == LO_LAST) state_nxt = ST_FETCH;
            ST_FETCH:    state_nxt = ST_DECODE;
            ST_DECODE: begin
                case (dec_op)
                    OP_WRITE, OP_READ, OP_POLL: state_nxt = ST_ISSUE;
                    OP_DELAY:                   state_nxt = ST_DELAY;
                    OP_END:                     state_nxt = ST_DONE;
                    default:                    state_nxt = ST_ERR;
                endcase
            end
            ST_ISSUE:    if (cmd_ready) state_nxt = ST_WAIT_RSP;
            ST_WAIT_RSP: begin
                if (rsp_valid) begin
                    if (poll_miss) state_nxt = (poll_cnt == POLL_LAST) ? ST_ERR : ST_ISSUE;
                    else           state_nxt = adv_state;
                end
            end
            ST_DELAY:    if (dly_cnt == ent_data) state_nxt = adv_state;
            ST_DONE:     state_nxt = ST_IDLE;
            ST_ERR:      state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decoded from the current state and the registered entry.
    always_comb begin
        busy      = !((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));
        done      = (state == ST_DONE);
        o_reset   = (state == ST_RST_H);
        cmd_valid = (state == ST_ISSUE);
        cmd_word  = {rd_op, ent_addr, rd_op ? {DATA_W{1'b0}} : ent_data};
    end

    // Datapath: table pointer, entry latch, phase counters, read data, error flag.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            // NOTE: entry is reset too, so cmd_word reads zero straight out of reset.
            ptr      <= '0;
            entry    <= '0;
            rst_cnt  <= '0;
            poll_cnt <= '0;
            dly_cnt  <= '0;
            last_rd  <= '0;
            error    <= 1'b0;
            err_ptr  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        error   <= 1'b0;
                        ptr     <= '0;
                        rst_cnt <= '0;
                    end
                end
                ST_RST_H, ST_RST_L: rst_cnt <= (state_nxt != state) ? '0 : rst_cnt + 1'b1;
                ST_DECODE: begin
                    entry    <= tbl_data;
                    poll_cnt <= '0;
                    dly_cnt  <= '0;
                end
                ST_WAIT_RSP: begin
                    if (rsp_valid) begin
                        if (rd_op)     last_rd  <= rsp_data;
                        if (poll_miss) poll_cnt <= poll_cnt + 1'b1;
                    end
                end
                ST_DELAY: dly_cnt <= dly_cnt + 1'b1;
                ST_ERR: begin
                    error   <= 1'b1;
                    err_ptr <= ptr;
                end
                default: ;
            endcase
            if (step && !is_last) ptr <= ptr + 1'b1;
        end
    end

endmodule

// File: tb/tb_spi_cfg_sequencer.sv
// tb_spi_cfg_sequencer: directed bench with a table ROM and a small SPI engine
// model; expected values are written out by hand in each step.
module tb_spi_cfg_sequencer;

    localparam int DEP = 8;

    logic        clk_in = 1'b0;
    logic        rst_n, start, cmd_ready, rsp_valid;
    logic [7:0]  rsp_data;
    logic [25:0] tbl_data;
    logic        busy, done, error, o_reset, cmd_valid;
    logic [2:0]  err_ptr, tbl_addr;
    logic [15:0] cmd_word;
    logic [7:0]  last_rd;

    int n_checks = 0;
    int n_fail   = 0;

    // Table ROM and engine configuration (written by the main sequence only).
    logic [25:0] rom [DEP];
    logic [7:0]  rsp_tab [16];
    int          rsp_epoch = 0;
    int          stall_cfg = 0;
    int          rsp_lat   = 2;

    // Engine observations (written by the engine process only).
    logic [15:0] cmd_log [$];
    int          rise_cyc [$];
    int          rsp_cyc [$];
    int          stall_bad = 0;
    int          ecyc = 0;

    spi_cfg_sequencer #(
        .ADDR_W(7), .DATA_W(8), .DEPTH(DEP),
        .RST_HI_CYC(4), .RST_LO_CYC(6), .POLL_MAX(3)
    ) dut (
        .clk_in(clk_in), .rst_n(rst_n), .start(start),
        .busy(busy), .done(done), .error(error), .err_ptr(err_ptr),
        .o_reset(o_reset), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_word(cmd_word),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .last_rd(last_rd)
    );

    always #5 clk_in = ~clk_in;

    // Synchronous ROM: data follows the address by one clock.
    always @(posedge clk_in) tbl_data <= rom[tbl_addr];

    // SPI engine model, acting on falling edges.
    initial begin
        int          pend = 0;
        int          stall_left = 0;
        int          rsp_idx = 0;
        int          seen_epoch = 0;
        logic        prev_cv = 1'b0;
        logic [15:0] held = '0;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_data  = '0;
        forever begin
            @(negedge clk_in);
            ecyc++;
            rsp_valid = 1'b0;
            if (seen_epoch != rsp_epoch) begin
                seen_epoch = rsp_epoch;
                rsp_idx    = 0;
            end
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    rsp_valid = 1'b1;
                    rsp_data  = rsp_tab[rsp_idx % 16];
                    rsp_idx++;
                    rsp_cyc.push_back(ecyc);
                end
            end
            if (cmd_valid && !prev_cv) begin
                rise_cyc.push_back(ecyc);
                stall_left = stall_cfg;
                held       = cmd_word;
            end
            if (cmd_valid) begin
                if (cmd_word !== held) stall_bad++;
                if (stall_left > 0) begin
                    cmd_ready = 1'b0;
                    stall_left--;
                end else begin
                    cmd_ready = 1'b1;
                    cmd_log.push_back(cmd_word);
                    pend = rsp_lat;
                end
            end else begin
                cmd_ready = 1'b0;
            end
            prev_cv = cmd_valid;
        end
    end

    function automatic logic [25:0] ent(input logic [2:0] op, input logic [6:0] a,
                                        input logic [7:0] d, input logic [7:0] m);
        return {op, a, d, m};
    endfunction

    task automatic tick();
        @(negedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_rom(input logic [25:0] v);
        for (int i = 0; i < DEP; i++) rom[i] = v;
    endtask

    task automatic fill_rsp(input logic [7:0] v);
        for (int i = 0; i < 16; i++) rsp_tab[i] = v;
        rsp_epoch++;
    endtask

    // Pulse (or hold) start, measure the reset phases, then run until not busy.
    task automatic run_seq(input bit hold, output int hi, output int lo,
                           output int ncv, output int ndone);
        int cyc;
        hi = 0; lo = 0; ncv = 0; ndone = 0; cyc = 0;
        start = 1'b1;
        tick();
        if (!hold) start = 1'b0;
        while (o_reset === 1'b1 && hi < 1000) begin hi++; tick(); end
        while (busy === 1'b1 && o_reset === 1'b0 && cmd_valid !== 1'b1 && lo < 1000) begin
            lo++;
            tick();
        end
        while (busy === 1'b1 && cyc < 2000) begin
            if (cmd_valid === 1'b1) ncv++;
            tick();
            cyc++;
        end
        if (done === 1'b1) ndone = 1;
        check("no_hang", cyc < 2000, 1);
    endtask

    initial begin
        int hi, lo, ncv, ndone, cb, rb, sb, k, any_busy, gap;
        rst_n = 1'b0;
        start = 1'b0;
        fill_rom(ent(3'd4, 7'h00, 8'h00, 8'h00));
        fill_rsp(8'h00);

        // Reset state.
        tick(); tick();
        check("rst_busy", busy, 0);
        check("rst_flags", {done, error, o_reset, cmd_valid}, 0);
        check("rst_vec", {err_ptr, tbl_addr, last_rd, cmd_word}, 0);
        rst_n = 1'b1;
        tick();

        // Single write then END.
        rom[0] = ent(3'd0, 7'h00, 8'h20, 8'h00);
        cb = cmd_log.size();
        run_seq(0, hi, lo, ncv, ndone);
        check("t1_oreset_hi", hi, 4);
        check("t1_rstl_to_issue", lo, 8);
        check("t1_ncmd", cmd_log.size() - cb, 1);
        check("t1_cmd_word", cmd_log[cb], 16'h0020);
        check("t1_done", ndone, 1);
        check("t1_error", error, 0);
        tick();
        check("t1_done_one_cycle", done, 0);

        // POLL that matches on the third read.
        fill_rom(ent(3'd4, 7'h00, 8'h00, 8'h00));
        rom[0] = ent(3'd3, 7'h18, 8'h07, 8'h07);
        fill_rsp(8'h00);
        rsp_tab[0] = 8'h01; rsp_tab[1] = 8'h03; rsp_tab[2] = 8'h0F;
        cb = cmd_log.size();
        run_seq(0, hi, lo, ncv, ndone);
        check("t2_ncmd", cmd_log.size() - cb, 3);
        check("t2_cmd0", cmd_log[cb], 16'h9800);
        check("t2_cmd2", cmd_log[cb+2], 16'h9800);
        check("t2_issue_cycles", ncv, 3);
        check("t2_last_rd", last_rd, 8'h0F);
        check("t2_done", ndone, 1);
        tick();

        // POLL exhausting POLL_MAX after a write.
        fill_rom(ent(3'd4, 7'h00, 8'h00, 8'h00));
        rom[0] = ent(3'd0, 7'h05, 8'h11, 8'h00);
        rom[1] = ent(3'd3, 7'h18, 8'h07, 8'h07);
        fill_rsp(8'h00);
        cb = cmd_log.size();
        run_seq(0, hi, lo, ncv, ndone);
        check("t3_ncmd", cmd_log.size() - cb, 4);
        check("t3_cmd_write", cmd_log[cb], 16'h0511);
        check("t3_cmd_last_read", cmd_log[cb+3], 16'h9800);
        check("t3_no_done", ndone, 0);
        tick();
        check("t3_error", error, 1);
        check("t3_err_ptr", err_ptr, 1);
        check("t3_busy", busy, 0);
        check("t3_last_rd", last_rd, 8'h00);
        tick(); tick(); tick();
        check("t3_error_sticky", error, 1);

        // Stalled handshakes around a DELAY of data=5.
        fill_rom(ent(3'd4, 7'h00, 8'h00, 8'h00));
        rom[0] = ent(3'd0, 7'h01, 8'hA5, 8'h00);
        rom[1] = ent(3'd2, 7'h00, 8'h05, 8'h00);
        rom[2] = ent(3'd0, 7'h02, 8'h5A, 8'h00);
        fill_rsp(8'h00);
        stall_cfg = 10;
        cb = cmd_log.size();
        rb = rise_cyc.size();
        sb = rsp_cyc.size();
        k  = stall_bad;
        run_seq(0, hi, lo, ncv, ndone);
        stall_cfg = 0;
        check("t4_ncmd", cmd_log.size() - cb, 2);
        check("t4_cmd0", cmd_log[cb], 16'h01A5);
        check("t4_cmd1", cmd_log[cb+1], 16'h025A);
        check("t4_valid_cycles", ncv, 22);
        check("t4_word_stable", stall_bad - k, 0);
        gap = (rise_cyc.size() > rb + 1 && rsp_cyc.size() > sb) ? rise_cyc[rb+1] - rsp_cyc[sb] : -1;
        check("t4_delay_gap", gap, 11);
        check("t4_done", ndone, 1);
        check("t4_error_cleared", error, 0);
        tick();

        // READ then an illegal opcode.
        fill_rom(ent(3'd4, 7'h00, 8'h00, 8'h00));
        rom[0] = ent(3'd0, 7'h03, 8'h33, 8'h00);
        rom[1] = ent(3'd1, 7'h04, 8'h99, 8'h00);
        rom[2] = ent(3'd6, 7'h00, 8'h00, 8'h00);
        fill_rsp(8'h00);
        rsp_tab[1] = 8'hC3;
        cb = cmd_log.size();
        run_seq(0, hi, lo, ncv, ndone);
        check("t5_ncmd", cmd_log.size() - cb, 2);
        check("t5_cmd_read", cmd_log[cb+1], 16'h8400);
        tick();
        check("t5_last_rd", last_rd, 8'hC3);
        check("t5_error", error, 1);
        check("t5_err_ptr", err_ptr, 2);

        // No END anywhere: the walk stops at the last slot.
        fill_rom(ent(3'd2, 7'h00, 8'h00, 8'h00));
        cb = cmd_log.size();
        run_seq(0, hi, lo, ncv, ndone);
        tick();
        check("t6_error", error, 1);
        check("t6_err_ptr", err_ptr, DEP - 1);
        check("t6_ncmd", cmd_log.size() - cb, 0);

        // Reset while waiting for a response, then a stray response.
        fill_rom(ent(3'd4, 7'h00, 8'h00, 8'h00));
        rom[0] = ent(3'd0, 7'h06, 8'h77, 8'h00);
        rom[1] = ent(3'd0, 7'h07, 8'h88, 8'h00);
        fill_rsp(8'h5C);
        rsp_lat = 6;
        start = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        while (cmd_valid !== 1'b1 && k < 200) begin tick(); k++; end
        check("t7_issue_seen", cmd_valid, 1);
        while (cmd_valid === 1'b1 && k < 200) begin tick(); k++; end
        rst_n = 1'b0;
        tick();
        check("t7_rst_flags", {busy, done, error, o_reset, cmd_valid}, 0);
        check("t7_rst_vec", {err_ptr, tbl_addr, last_rd}, 0);
        check("t7_rst_cmd_word", cmd_word, 0);
        tick();
        rst_n = 1'b1;
        cb = cmd_log.size();
        any_busy = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (busy === 1'b1 || done === 1'b1) any_busy++;
        end
        check("t7_stay_idle", any_busy, 0);
        check("t7_no_advance", tbl_addr, 0);
        check("t7_stray_ignored", last_rd, 0);
        check("t7_no_cmd", cmd_log.size() - cb, 0);
        rsp_lat = 2;
        run_seq(0, hi, lo, ncv, ndone);
        check("t7_rerun_ncmd", cmd_log.size() - cb, 2);
        check("t7_rerun_cmd0", cmd_log[cb], 16'h0677);
        check("t7_rerun_done", ndone, 1);
        check("t7_rerun_error", error, 0);
        tick();

        // Start held high: ignored while busy, restarts after DONE.
        fill_rom(ent(3'd4, 7'h00, 8'h00, 8'h00));
        run_seq(1, hi, lo, ncv, ndone);
        check("t8_oreset_hi", hi, 4);
        check("t8_done", ndone, 1);
        tick();
        check("t8_idle", {busy, o_reset}, 0);
        tick();
        check("t8_restart", {busy, o_reset}, 2'b11);
        start = 1'b0;
        k = 0;
        while (busy === 1'b1 && k < 200) begin tick(); k++; end
        check("t8_second_done", done, 1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_cfg_sequencer.md
SPI_CFG_SEQUENCER -- requirements
Module: spi_cfg_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 7: SPI register address width.
REQ-002 SHALL have parameter DATA_W, default 8: SPI register data width.
REQ-003 SHALL have parameter DEPTH, default 64: number of table entries; PTR_W = clog2(DEPTH).
REQ-004 SHALL have parameters RST_HI_CYC, default 10000, and RST_LO_CYC, default 20000: device reset pulse and recovery lengths in clk_in cycles.
REQ-005 SHALL have parameter POLL_MAX, default 255: maximum read attempts per POLL entry.
REQ-006 SHALL define ENTRY_W = 3+ADDR_W+2*DATA_W, with fields {op[2:0], addr, data, mask} from MSB to LSB.
REQ-007 clk_in  in  1  clock; all logic on rising edge.
REQ-008 rst_n  in  1  synchronous, active-low reset.
REQ-009 start  in  1  level; sampled only in IDLE.
REQ-010 busy  out  1  high in every state except IDLE, DONE and ERR.
REQ-011 done  out  1  one-cycle pulse on sequence completion.
REQ-012 error  out  1  sticky until the next accepted start or reset.
REQ-013 err_ptr  out  PTR_W  table index of the failing entry.
REQ-014 o_reset  out  1  device hard reset, active high.
REQ-015 tbl_addr  out  PTR_W  table read address.
REQ-016 tbl_data  in  ENTRY_W  table word; valid exactly one cycle after tbl_addr changes (synchronous ROM).
REQ-017 cmd_valid  out  1  SPI engine command request.
REQ-018 cmd_ready  in  1  engine accepts the command when cmd_valid and cmd_ready are both high.
REQ-019 cmd_word  out  1+ADDR_W+DATA_W  {rw, addr, data}; rw=1 means read, and the data field is 0 for reads.
REQ-020 rsp_valid  in  1  one-cycle pulse when the engine finishes a transaction.
REQ-021 rsp_data  in  DATA_W  read data; valid with rsp_valid.
REQ-022 last_rd  out  DATA_W  most recent read or poll data.

Function
REQ-023 Opcodes SHALL be: 0 WRITE, 1 READ, 2 DELAY (wait data+1 cycles), 3 POLL (repeat a read until (rsp_data & mask) == (data & mask)), 4 END. Opcodes 5-7 SHALL go to ERR.
REQ-024 The state set SHALL be IDLE, RST_H, RST_L, FETCH, DECODE, ISSUE, WAIT_RSP, DELAY, DONE, ERR.
REQ-025 IDLE + start SHALL go to RST_H, clear error, and set ptr=0.
REQ-026 RST_H SHALL drive o_reset=1 for exactly RST_HI_CYC cycles, then go to RST_L.
REQ-027 RST_L SHALL drive o_reset=0 for exactly RST_LO_CYC cycles, then go to FETCH.
REQ-028 FETCH SHALL present tbl_addr=ptr for 1 cycle; DECODE SHALL register tbl_data.
REQ-029 In ISSUE, cmd_valid SHALL be high and cmd_word stable until the handshake; cmd_valid SHALL fall in the cycle after acceptance.
REQ-030 WAIT_RSP SHALL hold until rsp_valid; a rsp_valid outside WAIT_RSP SHALL be ignored.
REQ-031 WRITE/READ entries: on rsp_valid, SHALL set ptr+1 and go to FETCH; READ SHALL load last_rd.
REQ-032 POLL on match SHALL advance the entry.
REQ-033 POLL on mismatch SHALL re-enter ISSUE and increment the attempt counter; reaching attempt count POLL_MAX without a match SHALL go to ERR. The attempt counter SHALL reset per entry.
REQ-034 DELAY SHALL issue no SPI command, count data+1 cycles, then advance (data=0 gives 1 cycle).
REQ-035 END SHALL go to DONE; DONE SHALL pulse done for 1 cycle, then go to IDLE.
REQ-036 If ptr reaches DEPTH-1 without END, then after executing that entry the block SHALL go to ERR with err_ptr=DEPTH-1 (no wrap-around).
REQ-037 ERR SHALL set error=1 and err_ptr=ptr, and return to IDLE after 1 cycle; error SHALL stay high.
REQ-038 start while busy SHALL be ignored; start held high through DONE SHALL restart the sequence from IDLE.

Reset
REQ-039 rst_n=0 at any time, including mid-transaction, SHALL force within 1 cycle: IDLE; busy, done, error, o_reset, cmd_valid = 0; err_ptr, tbl_addr, last_rd, ptr and counters = 0.
REQ-040 The block SHALL not wait for an outstanding engine response after reset; any later rsp_valid SHALL be ignored.

Verification
REQ-041 RST_HI_CYC=4, RST_LO_CYC=6, table {WRITE 0x00/0x20, END}, start pulse -> o_reset high 4 cycles, low 6; one cmd_word=0x0020; done pulse; error=0.
REQ-042 POLL addr 0x18 data 0x07 mask 0x07; engine returns 0x01, 0x03, 0x0F -> 3 read commands (0x9800), last_rd=0x0F, advance.
REQ-043 POLL_MAX=3, engine always returns 0x00 -> exactly 3 reads, then error=1, err_ptr=index of the POLL entry, busy=0.
REQ-044 cmd_ready held low 10 cycles in ISSUE -> cmd_valid and cmd_word stable throughout; exactly one command accepted.
REQ-045 DELAY data=5 -> 6 cycles with no cmd_valid between the neighbouring commands; opcode 6 entry -> ERR with err_ptr correct.
REQ-046 rst_n low during WAIT_RSP, stray rsp_valid after release -> IDLE, all outputs 0, no advance; a new start then runs cleanly.
